c7bifu_fcl_mo: RTL and testbench

C7BIFU_FCL_MO -- requirements
Module: c7bifu_fcl_mo

---
 rtl/c7bifu_pkg.sv | 31 +++
 rtl/c7bifu_updn_cnt.sv | 41 ++++
 rtl/c7bifu_fcl_mo.sv | 151 +++++++++++++++
 tb/tb_c7bifu_fcl_mo.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7bifu_pkg.sv
// Shared types for the IFU fetch-control block: pf address select index and sizing bounds.
package c7bifu_pkg;

   localparam int unsigned MAX_OUTSTANDING_LIMIT = 8;

   typedef enum logic [2:0] {
      SelInit,
      SelIsr,
      SelErt,
      SelBrn,
      SelInc,
      SelOld
   } pf_sel_e;

   // Bit order {init, isr, ert, brn, inc, old}.
   function automatic logic [5:0] sel_onehot(input pf_sel_e sel);
      logic [5:0] oh;
      oh = '0;
      unique case (sel)
         SelInit: oh = 6'b100000;
         SelIsr:  oh = 6'b010000;
         SelErt:  oh = 6'b001000;
         SelBrn:  oh = 6'b000100;
         SelInc:  oh = 6'b000010;
         SelOld:  oh = 6'b000001;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/c7bifu_updn_cnt.sv
// Saturating up/down counter with parallel load; clamps at 0 and at MAX.
module c7bifu_updn_cnt #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned MAX   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_cnt
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_load) begin
         w_cnt_nxt = i_load_val;
      end else if (i_inc && !i_dec && (r_cnt != MaxVal)) begin
         w_cnt_nxt = r_cnt + WIDTH'(1);
      end else if (i_dec && !i_inc && (r_cnt != '0)) begin
         w_cnt_nxt = r_cnt - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/c7bifu_fcl_mo.sv
// IFU fetch control: pf address select, request throttling and flush cancellation of
// in-flight responses. Define C7BIFU_FCL_PERF_EN to add the perf_cancel_cnt counter.
module c7bifu_fcl_mo
   import c7bifu_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             reset,
   output logic             ifu_icu_req_ic1,
   input  logic             icu_ifu_ack_ic1,
   input  logic             icu_ifu_data_valid_ic2,
   input  logic             ibuf_full,
   input  logic             exu_ifu_except,
   input  logic             exu_ifu_branch,
   input  logic             exu_ifu_ertn,
   output logic             pf_addr_sel_init,
   output logic             pf_addr_sel_old,
   output logic             pf_addr_sel_inc,
   output logic             pf_addr_sel_brn,
   output logic             pf_addr_sel_isr,
   output logic             pf_addr_sel_ert,
   output logic             pf_addr_en,
   output logic             icu_data_vld,
   output logic [CNT_W-1:0] outstanding_cnt,
   output logic             proto_err
`ifdef C7BIFU_FCL_PERF_EN
   ,
   output logic [15:0]      perf_cancel_cnt
`endif
);

   if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT)) begin : g_param_chk
      $error("MAX_OUTSTANDING out of range");
   end

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

   logic             r_init;
   logic             r_req;
   logic             r_proto_err;
   logic             w_flush;
   logic             w_req_ack;
   logic             w_req_nxt;
   logic             w_cnt_room;
   logic [CNT_W:0]   w_cnt_ack;
   logic [CNT_W-1:0] w_cancel_cnt;
   logic [CNT_W-1:0] w_cancel_load;
   pf_sel_e          w_sel;

   assign w_flush   = exu_ifu_except | exu_ifu_branch | exu_ifu_ertn;
   assign w_req_ack = r_req & icu_ifu_ack_ic1;

   // Room check counts a request acked this cycle, so a new one never overshoots the limit.
   assign w_cnt_ack  = {1'b0, outstanding_cnt} + {{CNT_W{1'b0}}, w_req_ack};
   assign w_cnt_room = w_cnt_ack < {1'b0, MaxCnt};
   assign w_req_nxt  = ~r_init & ((r_req & ~icu_ifu_ack_ic1) | (~ibuf_full & w_cnt_room));

   always_comb begin
      if (r_init) begin
         w_sel = SelInit;
      end else if (exu_ifu_except) begin
         w_sel = SelIsr;
      end else if (exu_ifu_ertn) begin
         w_sel = SelErt;
      end else if (exu_ifu_branch) begin
         w_sel = SelBrn;
      end else if (w_req_ack) begin
         w_sel = SelInc;
      end else begin
         w_sel = SelOld;
      end
   end

   assign {pf_addr_sel_init, pf_addr_sel_isr, pf_addr_sel_ert,
           pf_addr_sel_brn, pf_addr_sel_inc, pf_addr_sel_old} = reset ? 6'b0 : sel_onehot(w_sel);

   assign pf_addr_en      = ~reset & (r_init | w_flush | w_req_ack);
   assign ifu_icu_req_ic1 = r_req;
   assign icu_data_vld    = ~reset & icu_ifu_data_valid_ic2 & (w_cancel_cnt == '0);
   assign proto_err       = r_proto_err;

   // Everything still in flight after this cycle's ack/return becomes stale on a flush.
   always_comb begin
      w_cancel_load = outstanding_cnt;
      if (icu_ifu_ack_ic1 && !icu_ifu_data_valid_ic2 && (outstanding_cnt != MaxCnt)) begin
         w_cancel_load = outstanding_cnt + CNT_W'(1);
      end else if (icu_ifu_data_valid_ic2 && !icu_ifu_ack_ic1 && (outstanding_cnt != '0)) begin
         w_cancel_load = outstanding_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_init      <= 1'b1;
         r_req       <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_init <= 1'b0;
         r_req  <= w_req_nxt;
         if (icu_ifu_data_valid_ic2 && (outstanding_cnt == '0) && !icu_ifu_ack_ic1) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   c7bifu_updn_cnt #(
      .WIDTH (CNT_W),
      .MAX   (MAX_OUTSTANDING)
   ) u_outstanding_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (1'b0),
      .i_load_val ({CNT_W{1'b0}}),
      .i_inc      (icu_ifu_ack_ic1),
      .i_dec      (icu_ifu_data_valid_ic2),
      .o_cnt      (outstanding_cnt)
   );

   c7bifu_updn_cnt #(
      .WIDTH (CNT_W),
      .MAX   (MAX_OUTSTANDING)
   ) u_cancel_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_flush),
      .i_load_val (w_cancel_load),
      .i_inc      (1'b0),
      .i_dec      (icu_ifu_data_valid_ic2),
      .o_cnt      (w_cancel_cnt)
   );

`ifdef C7BIFU_FCL_PERF_EN
   logic        w_drop;
   logic [15:0] r_perf_cancel_cnt;

   assign w_drop = icu_ifu_data_valid_ic2 & (w_cancel_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_cancel_cnt <= '0;
      end else if (w_drop && (r_perf_cancel_cnt != 16'hFFFF)) begin
         r_perf_cancel_cnt <= r_perf_cancel_cnt + 16'd1;
      end
   end

   assign perf_cancel_cnt = r_perf_cancel_cnt;
`endif

endmodule

// File: tb/tb_c7bifu_fcl_mo.sv
// Self-checking bench for c7bifu_fcl_mo: directed scenarios plus randomized traffic
// checked against an in-order response queue model.
module tb_c7bifu_fcl_mo;

   localparam int unsigned MAX_OUT = 2;
   localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

   localparam logic [5:0] S_INIT = 6'b100000;
   localparam logic [5:0] S_ISR  = 6'b010000;
   localparam logic [5:0] S_ERT  = 6'b001000;
   localparam logic [5:0] S_BRN  = 6'b000100;
   localparam logic [5:0] S_INC  = 6'b000010;
   localparam logic [5:0] S_OLD  = 6'b000001;

   logic clk = 1'b0;
   logic reset, ack, dv, full, exc, brn, ert;
   logic req, s_init, s_old, s_inc, s_brn, s_isr, s_ert, en, vld, perr;
   logic [CNT_W-1:0] cnt;
   logic [5:0] w_sel;
`ifdef C7BIFU_FCL_PERF_EN
   logic [15:0] perf;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model: queue of in-flight responses, each flagged stale once a flush has passed it.
   bit m_init;
   bit m_req;
   bit m_q[$];
   bit m_proto;
   int m_perf;

   assign w_sel = {s_init, s_isr, s_ert, s_brn, s_inc, s_old};

   always #5 clk = ~clk;

   c7bifu_fcl_mo #(
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .ifu_icu_req_ic1        (req),
      .icu_ifu_ack_ic1        (ack),
      .icu_ifu_data_valid_ic2 (dv),
      .ibuf_full              (full),
      .exu_ifu_except         (exc),
      .exu_ifu_branch         (brn),
      .exu_ifu_ertn           (ert),
      .pf_addr_sel_init       (s_init),
      .pf_addr_sel_old        (s_old),
      .pf_addr_sel_inc        (s_inc),
      .pf_addr_sel_brn        (s_brn),
      .pf_addr_sel_isr        (s_isr),
      .pf_addr_sel_ert        (s_ert),
      .pf_addr_en             (en),
      .icu_data_vld           (vld),
      .outstanding_cnt        (cnt),
      .proto_err              (perr)
`ifdef C7BIFU_FCL_PERF_EN
      ,
      .perf_cancel_cnt        (perf)
`endif
   );

   function automatic logic [5:0] exp_sel();
      if (reset) return 6'b0;
      if (m_init) return S_INIT;
      if (exc) return S_ISR;
      if (ert) return S_ERT;
      if (brn) return S_BRN;
      if (m_req && ack) return S_INC;
      return S_OLD;
   endfunction

   function automatic logic exp_en();
      return !reset && (m_init || exc || brn || ert || (m_req && ack));
   endfunction

   function automatic logic exp_vld();
      return !reset && dv && ((m_q.size() == 0) || !m_q[0]);
   endfunction

   task automatic model_step();
      int unsigned sz;
      bit          nreq;
      if (reset) begin
         m_init = 1; m_req = 0; m_q.delete(); m_proto = 0; m_perf = 0;
      end else begin
         sz   = m_q.size();
         nreq = !m_init && ((m_req && !ack) ||
                            (!full && (sz + ((m_req && ack) ? 1 : 0) < MAX_OUT)));
         if (dv && sz > 0 && m_q[0] && m_perf < 65535) m_perf++;
         if (dv && sz == 0 && !ack) m_proto = 1;
         if (ack && sz < MAX_OUT) m_q.push_back(1'b0);
         if (dv && m_q.size() > 0) void'(m_q.pop_front());
         if (exc || brn || ert) foreach (m_q[i]) m_q[i] = 1'b1;
         m_req  = nreq;
         m_init = 0;
      end
   endtask

   task automatic set_in(input bit a, input bit d, input bit f, input bit e, input bit b,
                         input bit r);
      ack = a; dv = d; full = f; exc = e; brn = b; ert = r;
      #1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      cycle();
      cycle();
      reset = 1'b0;
      #1;
   endtask

   // Leaves the block one cycle after an ack: cnt=1, req=1.
   task automatic one_out();
      do_reset();
      cycle();
      cycle();
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   // Leaves the block with two outstanding and req low.
   task automatic fill_two();
      one_out();
      cycle();
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(1, 1, 0, 1, 1, 1);
      cycle();
      cycle();
      n_vec++; if (w_sel !== 6'b0) begin n_err++; $display("FAIL rst_sel: got %b want 000000", w_sel); end
      n_vec++; if ({en, vld, req, perr} !== 4'b0) begin n_err++; $display("FAIL rst_ctl: got %b want 0000", {en, vld, req, perr}); end
      n_vec++; if (cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if (w_sel !== S_INIT) begin n_err++; $display("FAIL rel_sel: got %b want %b", w_sel, S_INIT); end
      n_vec++; if ({en, req} !== 2'b10) begin n_err++; $display("FAIL rel_en_req: got %b want 10", {en, req}); end
   endtask

   task automatic test_init_req();
      do_reset();
      cycle();
      n_vec++; if ({w_sel, en, req} !== {S_OLD, 2'b00}) begin n_err++; $display("FAIL post_init: got %b want %b", {w_sel, en, req}, {S_OLD, 2'b00}); end
      cycle();
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL req_rise: got %b want 1", req); end
      cycle();
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL req_hold: got %b want 1", req); end
      cycle();
      set_in(1, 0, 0, 0, 0, 0);
      n_vec++; if ({w_sel, en} !== {S_INC, 1'b1}) begin n_err++; $display("FAIL ack_inc: got %b want %b", {w_sel, en}, {S_INC, 1'b1}); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if ({cnt, req} !== {CNT_W'(1), 1'b1}) begin n_err++; $display("FAIL ack_cnt: got %0d/%b want 1/1", cnt, req); end
   endtask

   task automatic test_max_outstanding();
      bit low_ok;
      do_reset();
      cycle();
      cycle();
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      cycle();
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if ({cnt, req} !== {CNT_W'(2), 1'b0}) begin n_err++; $display("FAIL max_cnt: got %0d/%b want 2/0", cnt, req); end
      low_ok = 1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (req !== 1'b0 || cnt !== CNT_W'(2)) low_ok = 0;
      end
      n_vec++; if (!low_ok) begin n_err++; $display("FAIL max_hold: got req %b cnt %0d want 0/2", req, cnt); end
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if ({req, vld} !== 2'b01) begin n_err++; $display("FAIL max_dv: got %b want 01", {req, vld}); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if ({cnt, req} !== {CNT_W'(1), 1'b0}) begin n_err++; $display("FAIL max_after_dv: got %0d/%b want 1/0", cnt, req); end
      cycle();
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL max_req_back: got %b want 1", req); end
   endtask

   task automatic test_branch_cancel();
      fill_two();
      set_in(0, 0, 0, 0, 1, 0);
      n_vec++; if ({w_sel, en} !== {S_BRN, 1'b1}) begin n_err++; $display("FAIL brn_sel: got %b want %b", {w_sel, en}, {S_BRN, 1'b1}); end
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL brn_drop1: got %b want 0", vld); end
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL brn_drop2: got %b want 0", vld); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && req !== 1'b1; i++) cycle();
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL brn_req_timeout: got %b want 1", req); end
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL brn_third: got %b want 1", vld); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_flush_ack();
      one_out();
      set_in(1, 0, 0, 0, 1, 0);
      n_vec++; if ({w_sel, en} !== {S_BRN, 1'b1}) begin n_err++; $display("FAIL fa_sel: got %b want %b", {w_sel, en}, {S_BRN, 1'b1}); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if ({cnt, req} !== {CNT_W'(2), 1'b0}) begin n_err++; $display("FAIL fa_cnt: got %0d/%b want 2/0", cnt, req); end
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL fa_drop1: got %b want 0", vld); end
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL fa_drop2: got %b want 0", vld); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && req !== 1'b1; i++) cycle();
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL fa_fresh: got %b want 1", vld); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_except_dv();
      one_out();
      set_in(0, 1, 0, 1, 0, 0);
      n_vec++; if ({w_sel, vld} !== {S_ISR, 1'b1}) begin n_err++; $display("FAIL ex_dv: got %b want %b", {w_sel, vld}, {S_ISR, 1'b1}); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if ({cnt, req} !== {CNT_W'(0), 1'b1}) begin n_err++; $display("FAIL ex_cnt: got %0d/%b want 0/1", cnt, req); end
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL ex_no_cancel: got %b want 1", vld); end
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL ex_perr: got %b want 0", perr); end
   endtask

   task automatic test_proto_err();
      do_reset();
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if ({perr, cnt} !== {1'b1, CNT_W'(0)}) begin n_err++; $display("FAIL pe_set: got %b/%0d want 1/0", perr, cnt); end
      cycle(); cycle(); cycle();
      n_vec++; if (perr !== 1'b1) begin n_err++; $display("FAIL pe_sticky: got %b want 1", perr); end
      one_out();
      n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL pe_clear: got %b want 0", perr); end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      n_vec++; if (cnt !== '0) begin n_err++; $display("FAIL pe_mid_rst_cnt: got %0d want 0", cnt); end
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if (perr !== 1'b1) begin n_err++; $display("FAIL pe_after_rst: got %b want 1", perr); end
   endtask

`ifdef C7BIFU_FCL_PERF_EN
   task automatic test_perf();
      do_reset();
      n_vec++; if (perf !== 16'd0) begin n_err++; $display("FAIL perf_rst: got %0d want 0", perf); end
      fill_two();
      set_in(0, 0, 0, 0, 1, 0);
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      cycle();
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && req !== 1'b1; i++) cycle();
      set_in(1, 0, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 1, 0, 0);
      cycle();
      set_in(0, 1, 0, 0, 0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0);
      n_vec++; if (perf !== 16'd3) begin n_err++; $display("FAIL perf_three: got %0d want 3", perf); end
   endtask
`endif

   task automatic test_random();
      bit a, d, f, e, b, r;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         a = m_req && ($urandom_range(0, 1) == 1);
         d = (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
         f = ($urandom_range(0, 4) == 0);
         e = ($urandom_range(0, 39) == 0);
         b = ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 39) == 0);
         set_in(a, d, f, e, b, r);
         n_vec++; if (w_sel !== exp_sel()) begin n_err++; $display("FAIL rnd_sel @%0d: got %b want %b", i, w_sel, exp_sel()); end
         n_vec++; if (en !== exp_en()) begin n_err++; $display("FAIL rnd_en @%0d: got %b want %b", i, en, exp_en()); end
         n_vec++; if (vld !== exp_vld()) begin n_err++; $display("FAIL rnd_vld @%0d: got %b want %b", i, vld, exp_vld()); end
         n_vec++; if (req !== m_req) begin n_err++; $display("FAIL rnd_req @%0d: got %b want %b", i, req, m_req); end
         n_vec++; if (cnt !== CNT_W'(m_q.size())) begin n_err++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, cnt, m_q.size()); end
         n_vec++; if (perr !== m_proto) begin n_err++; $display("FAIL rnd_perr @%0d: got %b want %b", i, perr, m_proto); end
`ifdef C7BIFU_FCL_PERF_EN
         n_vec++; if (perf !== 16'(m_perf)) begin n_err++; $display("FAIL rnd_perf @%0d: got %0d want %0d", i, perf, m_perf); end
`endif
         cycle();
      end
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      ack = 0; dv = 0; full = 0; exc = 0; brn = 0; ert = 0;
      test_reset();
      test_init_req();
      test_max_outstanding();
      test_branch_cancel();
      test_flush_ack();
      test_except_dv();
      test_proto_err();
`ifdef C7BIFU_FCL_PERF_EN
      test_perf();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
